// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder: turns decoded requests into 32-bit words tagged with an instruction-memory address.
// Latency: one cycle from request acceptance to OutValid (the encoded word is registered in a 2-entry output FIFO).
// Backpressure: InReady = FIFO not full (registered state only); OutReady stalls the head, rejected requests set sticky Err.

// Small synchronous FIFO used as the encoder's output buffer.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; push and pop in one cycle keep occupancy.
module instr_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign do_push    = push_i & ~full_o;
    assign do_pop     = pop_i & ~empty_o;
    assign head_dat_o = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap explicitly so any depth works.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control state with synchronous flush; storage needs no reset because the head is qualified by empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
            end
        end
    end
endmodule

module instr_encoder (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        InValid,
    output logic        InReady,
    input  logic [3:0]  Op,
    input  logic [4:0]  Rd,
    input  logic [4:0]  Rn,
    input  logic [4:0]  Rm,
    input  logic [25:0] Imm,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] Instr,
    output logic [7:0]  Addr,
    output logic        Err
);
    localparam logic [3:0] OP_LDUR = 4'd0;
    localparam logic [3:0] OP_STUR = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_ORR  = 4'd5;
    localparam logic [3:0] OP_CBZ  = 4'd6;
    localparam logic [3:0] OP_B    = 4'd7;
    localparam logic [3:0] OP_LSL  = 4'd8;
    localparam logic [3:0] OP_ORRI = 4'd9;

    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LSL  = 11'b11010011011;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [9:0]  OPC_ORRI = 10'b1011001000;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] word;
    } entry_t;

    logic        legal;
    logic [31:0] enc_word;
    logic        imm_s9_ok;
    logic        imm_s19_ok;
    logic        imm_u6_ok;
    logic        imm_u12_ok;
    logic        accept;
    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic        fifo_full;
    entry_t      push_ent;
    entry_t      head_ent;
    logic [7:0]  addr_q, addr_d;
    logic        err_q, err_d;

    // Immediate range checks: signed fields need all bits above the field's sign bit to match it.
    always_comb begin
        imm_s9_ok  = (&Imm[25:8])  | ~(|Imm[25:8]);
        imm_s19_ok = (&Imm[25:18]) | ~(|Imm[25:18]);
        imm_u6_ok  = ~(|Imm[25:6]);
        imm_u12_ok = ~(|Imm[25:12]);
    end

    // Combinational encode and legality of the presented request.
    always_comb begin
        enc_word = '0;
        legal    = 1'b0;
        unique case (Op)
            OP_LDUR: begin
                enc_word = {OPC_LDUR, Imm[8:0], 2'b00, Rn, Rd};
                legal    = imm_s9_ok;
            end
            OP_STUR: begin
                enc_word = {OPC_STUR, Imm[8:0], 2'b00, Rn, Rd};
                legal    = imm_s9_ok;
            end
            OP_ADD: begin
                enc_word = {OPC_ADD, Rm, 6'b0, Rn, Rd};
                legal    = 1'b1;
            end
            OP_SUB: begin
                enc_word = {OPC_SUB, Rm, 6'b0, Rn, Rd};
                legal    = 1'b1;
            end
            OP_AND: begin
                enc_word = {OPC_AND, Rm, 6'b0, Rn, Rd};
                legal    = 1'b1;
            end
            OP_ORR: begin
                enc_word = {OPC_ORR, Rm, 6'b0, Rn, Rd};
                legal    = 1'b1;
            end
            OP_CBZ: begin
                enc_word = {OPC_CBZ, Imm[18:0], Rd};
                legal    = imm_s19_ok;
            end
            OP_B: begin
                enc_word = {OPC_B, Imm[25:0]};
                legal    = 1'b1;
            end
            OP_LSL: begin
                enc_word = {OPC_LSL, 5'b0, Imm[5:0], Rn, Rd};
                legal    = imm_u6_ok;
            end
            OP_ORRI: begin
                enc_word = {OPC_ORRI, Imm[11:0], Rn, Rd};
                legal    = imm_u12_ok;
            end
            default: begin
                enc_word = '0;
                legal    = 1'b0;
            end
        endcase
    end

    // Handshakes: InReady comes only from FIFO state so it never depends on OutReady.
    always_comb begin
        InReady       = ~fifo_full;
        OutValid      = ~fifo_empty;
        accept        = InValid & InReady;
        push          = accept & legal;
        pop           = OutValid & OutReady;
        push_ent.addr = addr_q;
        push_ent.word = enc_word;
    end

    instr_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (2)
    ) u_out_fifo (
        .clk        (CLK),
        .rst        (Reset),
        .push_i     (push),
        .push_dat_i (push_ent),
        .pop_i      (pop),
        .head_dat_o (head_ent),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    // Address advances only for pushed words; rejected requests only raise the sticky error.
    always_comb begin
        addr_d = push ? addr_q + 8'd1 : addr_q;
        err_d  = err_q | (accept & ~legal);
    end

    // Address counter and sticky error; reset wins over any same-edge accept.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            err_q  <= err_d;
        end
    end

    // Head outputs are forced to zero whenever nothing is queued.
    always_comb begin
        Instr = fifo_empty ? 32'd0 : head_ent.word;
        Addr  = fifo_empty ? 8'd0  : head_ent.addr;
        Err   = err_q;
    end
endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
    logic        CLK = 1'b0;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [3:0]  Op;
    logic [4:0]  Rd, Rn, Rm;
    logic [25:0] Imm;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] Instr;
    logic [7:0]  Addr;
    logic        Err;

    always #5 CLK = ~CLK;

    instr_encoder dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .Op       (Op),
        .Rd       (Rd),
        .Rn       (Rn),
        .Rm       (Rm),
        .Imm      (Imm),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Instr    (Instr),
        .Addr     (Addr),
        .Err      (Err)
    );

    logic [39:0] sb[$];
    logic [7:0]  addr_m;
    logic        err_m;
    logic        cur_legal;
    logic [31:0] cur_word;
    logic        last_acc;
    int          n_assert;
    int          n_fail;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoder: range checks done on integer values.
    function automatic logic model(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                                   input logic [4:0] rm, input logic [25:0] imm, output logic [31:0] w);
        int s;
        int u;
        s = int'($signed(imm));
        u = int'(imm);
        w = 32'd0;
        model = 1'b1;
        case (op)
            4'd0: begin w = {11'h7C2, imm[8:0], 2'b00, rn, rd}; model = (s >= -256 && s <= 255); end
            4'd1: begin w = {11'h7C0, imm[8:0], 2'b00, rn, rd}; model = (s >= -256 && s <= 255); end
            4'd2: w = {11'h458, rm, 6'd0, rn, rd};
            4'd3: w = {11'h658, rm, 6'd0, rn, rd};
            4'd4: w = {11'h450, rm, 6'd0, rn, rd};
            4'd5: w = {11'h550, rm, 6'd0, rn, rd};
            4'd6: begin w = {8'hB4, imm[18:0], rd}; model = (s >= -262144 && s <= 262143); end
            4'd7: w = {6'b000101, imm};
            4'd8: begin w = {11'h69B, 5'd0, imm[5:0], rn, rd}; model = (u < 64); end
            4'd9: begin w = {10'h2C8, imm[11:0], rn, rd}; model = (u < 4096); end
            default: model = 1'b0;
        endcase
    endfunction

    // One clock: compare outputs against the scoreboard at the negedge, update the model, advance.
    task automatic cyc();
        logic acc;
        logic pop;
        check("err", Err, err_m);
        check("in_ready", InReady, sb.size() < 2);
        check("out_valid", OutValid, sb.size() != 0);
        if (sb.size() != 0) begin
            check("instr", Instr, sb[0][31:0]);
            check("addr", Addr, sb[0][39:32]);
        end else begin
            check("instr_idle", Instr, 0);
            check("addr_idle", Addr, 0);
        end
        acc = InValid && (sb.size() < 2);
        pop = (sb.size() != 0) && OutReady;
        last_acc = acc && !Reset;
        if (Reset) begin
            sb.delete();
            addr_m = 8'd0;
            err_m  = 1'b0;
        end else begin
            if (pop) void'(sb.pop_front());
            if (acc) begin
                if (cur_legal) begin
                    sb.push_back({addr_m, cur_word});
                    addr_m = addr_m + 8'd1;
                end else begin
                    err_m = 1'b1;
                end
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic req_lit(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                           input logic [4:0] rm, input logic [25:0] imm, input logic legal,
                           input logic [31:0] word);
        logic done;
        done = 1'b0;
        InValid = 1'b1; Op = op; Rd = rd; Rn = rn; Rm = rm; Imm = imm;
        cur_legal = legal; cur_word = word;
        for (int i = 0; i < 20 && !done; i++) begin
            cyc();
            done = last_acc;
        end
        check("accept_timeout", done, 1);
        InValid = 1'b0;
    endtask

    task automatic req(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                       input logic [4:0] rm, input logic [25:0] imm);
        logic [31:0] w;
        logic        l;
        l = model(op, rd, rn, rm, imm, w);
        req_lit(op, rd, rn, rm, imm, l, w);
    endtask

    task automatic drain();
        OutReady = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
        check("drain_timeout", sb.size(), 0);
        cyc();
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        sb.delete(); addr_m = 8'd0; err_m = 1'b0;
        cur_legal = 1'b0; cur_word = 32'd0; last_acc = 1'b0;
        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b1;
        Op = 4'd0; Rd = 5'd0; Rn = 5'd0; Rm = 5'd0; Imm = 26'd0;
        @(posedge CLK);
        @(negedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        cyc();

        // Reference vectors with hand-computed words.
        req_lit(4'd2, 5'd1, 5'd2, 5'd3, 26'd0, 1'b1, 32'h8B030041);
        check("add_addr0", Addr, 8'd0);
        check("add_vld", OutValid, 1);
        req_lit(4'd0, 5'd5, 5'd6, 5'd0, 26'h3FFFFF8, 1'b1, 32'hF85F80C5);
        req_lit(4'd6, 5'd9, 5'd0, 5'd0, 26'h3FFFFFF, 1'b1, 32'hB4FFFFE9);
        req_lit(4'd7, 5'd0, 5'd0, 5'd0, 26'd3, 1'b1, 32'h14000003);

        // Remaining opcodes, including immediate boundary values.
        req(4'd1, 5'd7, 5'd8, 5'd0, 26'd255);
        req(4'd0, 5'd3, 5'd4, 5'd0, 26'h3FFFF00);
        req(4'd3, 5'd31, 5'd30, 5'd29, 26'h155);
        req(4'd4, 5'd10, 5'd11, 5'd12, 26'd0);
        req(4'd5, 5'd13, 5'd14, 5'd15, 26'd0);
        req(4'd8, 5'd16, 5'd17, 5'd0, 26'd63);
        req(4'd9, 5'd18, 5'd19, 5'd0, 26'hFFF);
        req(4'd6, 5'd20, 5'd0, 5'd0, 26'h003FFFF);
        req(4'd7, 5'd0, 5'd0, 5'd0, 26'h2ABCDEF);
        drain();

        // Rejected requests: no push, Err sticks, address does not advance.
        req_lit(4'd9, 5'd1, 5'd1, 5'd0, 26'h1000, 1'b0, 32'd0);
        check("illegal_no_vld", OutValid, 0);
        req(4'd2, 5'd2, 5'd3, 5'd4, 26'd0);
        req(4'd12, 5'd1, 5'd1, 5'd1, 26'd0);
        req(4'd8, 5'd1, 5'd1, 5'd0, 26'd64);
        req(4'd0, 5'd1, 5'd1, 5'd0, 26'd256);
        req(4'd6, 5'd1, 5'd0, 5'd0, 26'h0040000);
        req(4'd15, 5'd1, 5'd1, 5'd1, 26'd0);
        req(4'd5, 5'd6, 5'd7, 5'd8, 26'd0);
        drain();
        check("err_sticky", Err, 1);

        // Reset with a full FIFO and a simultaneous request.
        OutReady = 1'b0;
        req(4'd2, 5'd1, 5'd1, 5'd1, 26'd0);
        req(4'd3, 5'd2, 5'd2, 5'd2, 26'd0);
        InValid = 1'b1; Op = 4'd2; cur_legal = 1'b1; cur_word = 32'hDEADBEEF;
        OutReady = 1'b1;
        Reset = 1'b1;
        cyc();
        Reset = 1'b0; InValid = 1'b0;
        cyc();
        check("rst_vld", OutValid, 0);
        check("rst_err", Err, 0);

        // Backpressure: two accepts fill the FIFO, the third waits.
        OutReady = 1'b0;
        req(4'd2, 5'd1, 5'd2, 5'd3, 26'd0);
        req(4'd2, 5'd4, 5'd5, 5'd6, 26'd0);
        begin
            logic [31:0] w;
            cur_legal = model(4'd2, 5'd7, 5'd8, 5'd9, 26'd0, w);
            cur_word = w;
        end
        InValid = 1'b1; Op = 4'd2; Rd = 5'd7; Rn = 5'd8; Rm = 5'd9; Imm = 26'd0;
        for (int i = 0; i < 3; i++) begin
            check("bp_ready", InReady, 0);
            cyc();
        end
        OutReady = 1'b1;
        begin
            logic done;
            done = 1'b0;
            for (int i = 0; i < 20 && !done; i++) begin
                cyc();
                done = last_acc;
            end
            check("bp_accept", done, 1);
        end
        InValid = 1'b0;
        drain();

        // Address wrap: 256 more words after the 3 above, then wrap through 0.
        for (int i = 0; i < 256; i++) begin
            req(4'($urandom_range(2, 5)), 5'($urandom), 5'($urandom), 5'($urandom), 26'd0);
        end
        req(4'd7, 5'd0, 5'd0, 5'd0, 26'd1);
        drain();
        check("wrap_err", Err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
